// File: rtl/ps2_key_state_decoder_pkg.sv
// ----------------------------------------------------------------------------
// ps2_key_state_decoder_pkg : scan codes, key indices, FSM states, code lookup.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ps2_key_state_decoder_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ACK   = 8'hFA;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_OVR0  = 8'h00;
  localparam logic [7:0] SC_OVR1  = 8'hFF;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam int KEY_Q = 0;
  localparam int KEY_W = 1;
  localparam int KEY_E = 2;
  localparam int KEY_R = 3;
  localparam int KEY_T = 4;
  localparam int KEY_Y = 5;
  localparam int KEY_U = 6;
  localparam int BASE_KEY_COUNT = 29;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BREAK     = 2'd1,
    ST_EXT       = 2'd2,
    ST_EXT_BREAK = 2'd3
  } dec_state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] idx;
  } key_lookup_t;

  function automatic key_lookup_t base_lookup(input logic [7:0] code);
    key_lookup_t r;
    r.valid = 1'b1;
    case (code)
      8'h15: r.idx = 8'd0;   8'h1D: r.idx = 8'd1;   8'h24: r.idx = 8'd2;
      8'h2D: r.idx = 8'd3;   8'h2C: r.idx = 8'd4;   8'h35: r.idx = 8'd5;
      8'h3C: r.idx = 8'd6;   8'h43: r.idx = 8'd7;   8'h44: r.idx = 8'd8;
      8'h4D: r.idx = 8'd9;   8'h1C: r.idx = 8'd10;  8'h1B: r.idx = 8'd11;
      8'h23: r.idx = 8'd12;  8'h2B: r.idx = 8'd13;  8'h34: r.idx = 8'd14;
      8'h33: r.idx = 8'd15;  8'h3B: r.idx = 8'd16;  8'h42: r.idx = 8'd17;
      8'h4B: r.idx = 8'd18;  8'h1A: r.idx = 8'd19;  8'h22: r.idx = 8'd20;
      8'h21: r.idx = 8'd21;  8'h2A: r.idx = 8'd22;  8'h32: r.idx = 8'd23;
      8'h31: r.idx = 8'd24;  8'h3A: r.idx = 8'd25;  8'h29: r.idx = 8'd26;
      8'h5A: r.idx = 8'd27;  8'h76: r.idx = 8'd28;
      default: begin
        r.valid = 1'b0;
        r.idx   = 8'd0;
      end
    endcase
    return r;
  endfunction

  // Index is an offset above the base key range.
  function automatic key_lookup_t ext_lookup(input logic [7:0] code);
    key_lookup_t r;
    r.valid = 1'b1;
    case (code)
      SC_UP:    r.idx = 8'd0;
      SC_DOWN:  r.idx = 8'd1;
      SC_LEFT:  r.idx = 8'd2;
      SC_RIGHT: r.idx = 8'd3;
      default: begin
        r.valid = 1'b0;
        r.idx   = 8'd0;
      end
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_event_fifo.sv
// ----------------------------------------------------------------------------
// ps2_event_fifo : synchronous FIFO with combinational head and sticky overflow.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ps2_event_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             empty_w;
  logic             full_w;
  logic             pop_w;
  logic             wr_en_w;

  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == CNT_W'(DEPTH));
  assign pop_w   = ready_i && !empty_w;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en_w = push_i && (!full_w || pop_w);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en_w) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({wr_en_w, pop_w})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push_i && !wr_en_w) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign valid_o    = !empty_w;
  assign data_o     = empty_w ? '0 : mem_q[rd_ptr_q];
  assign overflow_o = overflow_q;

endmodule

`default_nettype wire

// File: rtl/ps2_key_state_decoder.sv
// ----------------------------------------------------------------------------
// ps2_key_state_decoder : PS/2 make/break decoder -> key-state vector + event FIFO.
// Define PS2_EXTENDED_KEYS_EN to map E0 arrow keys above NUM_KEYS.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ps2_key_state_decoder
  import ps2_key_state_decoder_pkg::*;
#(
  parameter int NUM_KEYS       = 29,
  parameter int EVENT_DEPTH    = 4,
  parameter int TIMEOUT_CYCLES = 50000,
`ifdef PS2_EXTENDED_KEYS_EN
  localparam int KEY_W = NUM_KEYS + 4,
`else
  localparam int KEY_W = NUM_KEYS,
`endif
  localparam int IDX_W = $clog2(KEY_W)
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic [7:0]       recievedData,
  input  logic             recievedNewData,
  input  logic             clearAll,
  output logic [KEY_W-1:0] inputStateStorage,
  output logic             keyReleasePulse,
  output logic             eventValid,
  output logic             eventIsPress,
  output logic [IDX_W-1:0] eventKey,
  input  logic             eventReady,
  output logic             eventOverflow
);

  localparam int               CNT_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [8:0]       NUM_KEYS_L   = 9'(NUM_KEYS);
`ifdef PS2_EXTENDED_KEYS_EN
  localparam logic [IDX_W-1:0] EXT_BASE     = IDX_W'(NUM_KEYS);
  key_lookup_t ext_lu_w;
`endif

  dec_state_e       state_q;
  dec_state_e       state_d;
  logic [CNT_W-1:0] tmo_cnt_q;
  logic [KEY_W-1:0] keys_q;
  logic             rel_pulse_q;

  key_lookup_t      base_lu_w;
  logic             hit_valid_w;
  logic [IDX_W-1:0] hit_idx_w;
  logic             hit_break_w;
  logic             overrun_w;
  logic             push_w;
  logic [IDX_W:0]   push_data_w;
  logic [IDX_W:0]   head_w;

  always_comb begin
    base_lu_w   = base_lookup(recievedData);
`ifdef PS2_EXTENDED_KEYS_EN
    ext_lu_w    = ext_lookup(recievedData);
`endif
    state_d     = state_q;
    hit_valid_w = 1'b0;
    hit_idx_w   = '0;
    hit_break_w = 1'b0;
    overrun_w   = 1'b0;
    if (recievedNewData) begin
      if (recievedData == SC_OVR0 || recievedData == SC_OVR1) begin
        overrun_w = 1'b1;
        state_d   = ST_IDLE;
      end else if (recievedData == SC_EXT) begin
        state_d = ST_EXT;
      end else if (recievedData == SC_BREAK) begin
        state_d = (state_q == ST_EXT || state_q == ST_EXT_BREAK) ? ST_EXT_BREAK : ST_BREAK;
      end else begin
        state_d     = ST_IDLE;
        hit_break_w = (state_q == ST_BREAK) || (state_q == ST_EXT_BREAK);
        if (state_q == ST_IDLE || state_q == ST_BREAK) begin
          hit_valid_w = base_lu_w.valid && ({1'b0, base_lu_w.idx} < NUM_KEYS_L);
          hit_idx_w   = IDX_W'(base_lu_w.idx);
        end
`ifdef PS2_EXTENDED_KEYS_EN
        else begin
          hit_valid_w = ext_lu_w.valid;
          hit_idx_w   = EXT_BASE + IDX_W'(ext_lu_w.idx);
        end
`endif
      end
    end
  end

  // Typematic repeats and breaks of released keys fall out here: no edge, no event.
  assign push_w      = hit_valid_w && (hit_break_w ? keys_q[hit_idx_w] : !keys_q[hit_idx_w]);
  assign push_data_w = {!hit_break_w, hit_idx_w};

  always_ff @(posedge CLOCK_50) begin
    if (resetn) begin
      state_q     <= ST_IDLE;
      tmo_cnt_q   <= '0;
      keys_q      <= '0;
      rel_pulse_q <= 1'b0;
    end else begin
      rel_pulse_q <= push_w && hit_break_w;
      if (clearAll || overrun_w) begin
        keys_q <= '0;
      end else if (push_w) begin
        keys_q[hit_idx_w] <= !hit_break_w;
      end
      if (recievedNewData) begin
        state_q   <= state_d;
        tmo_cnt_q <= '0;
      end else if (state_q != ST_IDLE) begin
        if (tmo_cnt_q == TIMEOUT_LAST) begin
          state_q   <= ST_IDLE;
          tmo_cnt_q <= '0;
        end else begin
          tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
      end else begin
        tmo_cnt_q <= '0;
      end
    end
  end

  ps2_event_fifo #(
    .WIDTH (IDX_W + 1),
    .DEPTH (EVENT_DEPTH)
  ) u_event_fifo (
    .clk_i       (CLOCK_50),
    .rst_i       (resetn),
    .push_i      (push_w),
    .push_data_i (push_data_w),
    .ready_i     (eventReady),
    .valid_o     (eventValid),
    .data_o      (head_w),
    .overflow_o  (eventOverflow)
  );

  assign inputStateStorage = keys_q;
  assign keyReleasePulse   = rel_pulse_q;
  assign eventIsPress      = head_w[IDX_W];
  assign eventKey          = head_w[IDX_W-1:0];

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_state_decoder.sv
// ----------------------------------------------------------------------------
// tb_ps2_key_state_decoder : directed self-checking bench for ps2_key_state_decoder.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ps2_key_state_decoder;

  localparam int NUM_KEYS = 29;
  localparam int TMO      = 20;
`ifdef PS2_EXTENDED_KEYS_EN
  localparam int KEY_W = NUM_KEYS + 4;
`else
  localparam int KEY_W = NUM_KEYS;
`endif
  localparam int IDX_W = $clog2(KEY_W);

  logic             CLOCK_50 = 1'b0;
  logic             resetn = 1'b1;
  logic [7:0]       recievedData = 8'h00;
  logic             recievedNewData = 1'b0;
  logic             clearAll = 1'b0;
  logic             eventReady = 1'b0;
  logic [KEY_W-1:0] inputStateStorage;
  logic             keyReleasePulse;
  logic             eventValid;
  logic             eventIsPress;
  logic [IDX_W-1:0] eventKey;
  logic             eventOverflow;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLOCK_50 = ~CLOCK_50;

  ps2_key_state_decoder #(
    .NUM_KEYS       (NUM_KEYS),
    .EVENT_DEPTH    (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .CLOCK_50          (CLOCK_50),
    .resetn            (resetn),
    .recievedData      (recievedData),
    .recievedNewData   (recievedNewData),
    .clearAll          (clearAll),
    .inputStateStorage (inputStateStorage),
    .keyReleasePulse   (keyReleasePulse),
    .eventValid        (eventValid),
    .eventIsPress      (eventIsPress),
    .eventKey          (eventKey),
    .eventReady        (eventReady),
    .eventOverflow     (eventOverflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic [7:0] b);
    recievedData    = b;
    recievedNewData = 1'b1;
    @(negedge CLOCK_50);
    recievedNewData = 1'b0;
  endtask

  task automatic pop();
    eventReady = 1'b1;
    @(negedge CLOCK_50);
    eventReady = 1'b0;
  endtask

  task automatic head(input string tag, input logic press, input logic [63:0] key);
    chk({tag, "_valid"}, 64'(eventValid), 64'h1);
    chk({tag, "_press"}, 64'(eventIsPress), 64'(press));
    chk({tag, "_key"}, 64'(eventKey), key);
  endtask

  initial begin
    @(negedge CLOCK_50);
    strobe(8'h15);
    repeat (2) @(negedge CLOCK_50);
    resetn = 1'b0;
    chk("rst_state", 64'(inputStateStorage), 64'h0);
    chk("rst_valid", 64'(eventValid), 64'h0);
    chk("rst_key", 64'(eventKey), 64'h0);
    chk("rst_press", 64'(eventIsPress), 64'h0);
    chk("rst_pulse", 64'(keyReleasePulse), 64'h0);
    chk("rst_ovf", 64'(eventOverflow), 64'h0);

    strobe(8'h15);
    chk("make_state", 64'(inputStateStorage), 64'h1);
    head("make", 1'b1, 64'd0);
    chk("make_pulse", 64'(keyReleasePulse), 64'h0);

    strobe(8'h15);
    strobe(8'h15);
    chk("rpt_state", 64'(inputStateStorage), 64'h1);
    pop();
    chk("rpt_one_event", 64'(eventValid), 64'h0);

    strobe(8'hF0);
    chk("f0_state", 64'(inputStateStorage), 64'h1);
    chk("f0_noevt", 64'(eventValid), 64'h0);
    strobe(8'h15);
    chk("brk_state", 64'(inputStateStorage), 64'h0);
    chk("brk_pulse", 64'(keyReleasePulse), 64'h1);
    head("brk", 1'b0, 64'd0);
    @(negedge CLOCK_50);
    chk("brk_pulse_end", 64'(keyReleasePulse), 64'h0);
    pop();

    strobe(8'hF0);
    strobe(8'h15);
    chk("brk0_noevt", 64'(eventValid), 64'h0);
    chk("brk0_pulse", 64'(keyReleasePulse), 64'h0);

    strobe(8'h15);
    pop();
    strobe(8'hF0);
    repeat (TMO - 1) @(negedge CLOCK_50);
    strobe(8'h15);
    chk("tmo_m1_state", 64'(inputStateStorage), 64'h0);
    head("tmo_m1", 1'b0, 64'd0);
    pop();
    strobe(8'hF0);
    repeat (TMO) @(negedge CLOCK_50);
    strobe(8'h15);
    chk("tmo_state", 64'(inputStateStorage), 64'h1);
    head("tmo", 1'b1, 64'd0);
    pop();

    clearAll = 1'b1;
    @(negedge CLOCK_50);
    clearAll = 1'b0;
    chk("clr_state", 64'(inputStateStorage), 64'h0);
    chk("clr_noevt", 64'(eventValid), 64'h0);

    strobe(8'h1D);
    strobe(8'h24);
    strobe(8'h2D);
    strobe(8'h2C);
    chk("full_ovf0", 64'(eventOverflow), 64'h0);
    strobe(8'h35);
    chk("ovf_set", 64'(eventOverflow), 64'h1);
    chk("ovf_state", 64'(inputStateStorage), 64'h3E);
    head("ovf_head", 1'b1, 64'd1);
    recievedData    = 8'h3C;
    recievedNewData = 1'b1;
    eventReady      = 1'b1;
    @(negedge CLOCK_50);
    recievedNewData = 1'b0;
    eventReady      = 1'b0;
    chk("fullpop_state", 64'(inputStateStorage), 64'h7E);
    head("fullpop_h0", 1'b1, 64'd2);
    pop();
    head("fullpop_h1", 1'b1, 64'd3);
    pop();
    head("fullpop_h2", 1'b1, 64'd4);
    pop();
    head("fullpop_h3", 1'b1, 64'd6);
    pop();
    chk("fifo_drained", 64'(eventValid), 64'h0);
    chk("ovf_sticky", 64'(eventOverflow), 64'h1);

    clearAll = 1'b1;
    strobe(8'h15);
    clearAll = 1'b0;
    chk("clrmake_state", 64'(inputStateStorage), 64'h0);
    head("clrmake", 1'b1, 64'd0);
    pop();

    strobe(8'hE0);
    strobe(8'h75);
`ifdef PS2_EXTENDED_KEYS_EN
    chk("ext_state", 64'(inputStateStorage), 64'h2000_0000);
    head("ext", 1'b1, 64'd29);
    pop();
`else
    chk("ext_state", 64'(inputStateStorage), 64'h0);
    chk("ext_noevt", 64'(eventValid), 64'h0);
`endif
    strobe(8'h15);
`ifdef PS2_EXTENDED_KEYS_EN
    chk("ext_q_state", 64'(inputStateStorage), 64'h2000_0001);
`else
    chk("ext_q_state", 64'(inputStateStorage), 64'h1);
`endif
    head("ext_q", 1'b1, 64'd0);
    pop();
    strobe(8'hE0);
    strobe(8'hF0);
    strobe(8'h75);
    chk("extbrk_state", 64'(inputStateStorage), 64'h1);
`ifdef PS2_EXTENDED_KEYS_EN
    chk("extbrk_pulse", 64'(keyReleasePulse), 64'h1);
    head("extbrk", 1'b0, 64'd29);
    pop();
`else
    chk("extbrk_pulse", 64'(keyReleasePulse), 64'h0);
    chk("extbrk_noevt", 64'(eventValid), 64'h0);
`endif

    strobe(8'h1D);
    chk("pre_ovr_state", 64'(inputStateStorage), 64'h3);
    pop();
    strobe(8'hFF);
    chk("ovr_state", 64'(inputStateStorage), 64'h0);
    chk("ovr_noevt", 64'(eventValid), 64'h0);
    strobe(8'hFA);
    strobe(8'hAA);
    chk("ack_state", 64'(inputStateStorage), 64'h0);
    chk("ack_noevt", 64'(eventValid), 64'h0);

    strobe(8'h15);
    pop();
    strobe(8'hF0);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    resetn = 1'b0;
    chk("midrst_state", 64'(inputStateStorage), 64'h0);
    chk("midrst_ovf", 64'(eventOverflow), 64'h0);
    strobe(8'h15);
    chk("midrst_make", 64'(inputStateStorage), 64'h1);
    head("midrst", 1'b1, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
